// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared core constants for the writeback path
package wb_arbiter_pkg;

    // Pipeline-wide widths and sizes.
    localparam int XLEN_DEFAULT = 32;
    localparam int NREG_DEFAULT = 32;
    localparam int REG_IDX_W    = 5;

    // x0 is hardwired zero: writes to it are dropped, it is never busy.
    localparam logic [REG_IDX_W-1:0] REG_ZERO = '0;

    // Writeback requester IDs.
    typedef enum logic {
        REQ_P0 = 1'b0,   // single-cycle pipeline writeback
        REQ_P1 = 1'b1    // multi-cycle unit writeback
    } req_id_t;

endpackage

// File: rtl/wb_scoreboard.sv
// rtl/wb_scoreboard.sv - busy-bit scoreboard for pending multi-cycle writes
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   set_en, set_idx       issue of a multi-cycle op to set_idx (x0 ignored)
//   clr_en, clr_idx       accepted multi-cycle writeback to clr_idx
//   pend_valid, pend_idx  multi-cycle writeback presented but not yet committed
//   rs1, rs2              lookup indices
//   rs1_busy, rs2_busy    lookup results
//   iss_conflict          one-cycle pulse: issue hit an already-busy register
module wb_scoreboard
    import wb_arbiter_pkg::*;
#(
    parameter int NREG = NREG_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 set_en,
    input  logic [REG_IDX_W-1:0] set_idx,
    input  logic                 clr_en,
    input  logic [REG_IDX_W-1:0] clr_idx,
    input  logic                 pend_valid,
    input  logic [REG_IDX_W-1:0] pend_idx,
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    output logic                 iss_conflict
);

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic            set_live;

    assign set_live = set_en && (set_idx != REG_ZERO);

    // Clear first, then set, so a same-index set and clear leaves the bit set.
    always_comb begin
        busy_nxt = busy;
        if (clr_en) begin
            busy_nxt[clr_idx] = 1'b0;
        end
        if (set_live) begin
            busy_nxt[set_idx] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy         <= '0;
            iss_conflict <= 1'b0;
        end else begin
            busy         <= busy_nxt;
            iss_conflict <= set_live && busy[set_idx];
        end
    end

    // A writeback still sitting at the requester (or accepted this cycle) has
    // not reached the register file, and there is no bypass, so it keeps its
    // destination busy too.
    always_comb begin
        rs1_busy = busy[rs1] | (pend_valid && (pend_idx == rs1) && (rs1 != REG_ZERO));
        rs2_busy = busy[rs2] | (pend_valid && (pend_idx == rs2) && (rs2 != REG_ZERO));
    end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - two-requester round-robin writeback arbiter with scoreboard
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   p0_valid/ready/rd/wd        pipeline writeback request (requester 0)
//   p1_valid/ready/rd/wd        multi-cycle unit writeback (requester 1)
//   iss_valid, iss_rd           multi-cycle op issue and its destination
//   rs1, rs2                    decode-stage source indices
//   rs1_busy, rs2_busy          source has a pending multi-cycle write
//   iss_conflict                issue targeted an already-busy register
//   reg_write, rd, wd           registered register file write port
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int NREG = NREG_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 p0_valid,
    output logic                 p0_ready,
    input  logic [REG_IDX_W-1:0] p0_rd,
    input  logic [XLEN-1:0]      p0_wd,
    input  logic                 p1_valid,
    output logic                 p1_ready,
    input  logic [REG_IDX_W-1:0] p1_rd,
    input  logic [XLEN-1:0]      p1_wd,
    input  logic                 iss_valid,
    input  logic [REG_IDX_W-1:0] iss_rd,
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    output logic                 iss_conflict,
    output logic                 reg_write,
    output logic [REG_IDX_W-1:0] rd,
    output logic [XLEN-1:0]      wd
);

    req_id_t              last_grant;
    logic                 acc0;
    logic                 acc1;
    logic [REG_IDX_W-1:0] sel_rd;
    logic [XLEN-1:0]      sel_wd;

    // On a tie the requester not granted last wins; ready is forced low while
    // reset is asserted so nothing is accepted during reset.
    always_comb begin
        p0_ready = rst_n & p0_valid & (~p1_valid | (last_grant == REQ_P1));
        p1_ready = rst_n & p1_valid & (~p0_valid | (last_grant == REQ_P0));
        acc0     = p0_valid & p0_ready;
        acc1     = p1_valid & p1_ready;
        sel_rd   = acc1 ? p1_rd : p0_rd;
        sel_wd   = acc1 ? p1_wd : p0_wd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= REQ_P1;
            reg_write  <= 1'b0;
            rd         <= '0;
            wd         <= '0;
        end else begin
            reg_write <= 1'b0;
            if (acc0 || acc1) begin
                last_grant <= acc1 ? REQ_P1 : REQ_P0;
                // x0 writes are consumed but never committed.
                reg_write  <= (sel_rd != REG_ZERO);
                rd         <= sel_rd;
                wd         <= sel_wd;
            end
        end
    end

    wb_scoreboard #(
        .NREG (NREG)
    ) u_scoreboard (
        .clk          (clk),
        .rst_n        (rst_n),
        .set_en       (iss_valid),
        .set_idx      (iss_rd),
        .clr_en       (acc1),
        .clr_idx      (p1_rd),
        .pend_valid   (p1_valid),
        .pend_idx     (p1_rd),
        .rs1          (rs1),
        .rs2          (rs2),
        .rs1_busy     (rs1_busy),
        .rs2_busy     (rs2_busy),
        .iss_conflict (iss_conflict)
    );

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed self-checking bench for wb_arbiter
module tb_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        p0_valid;
    logic        p0_ready;
    logic [4:0]  p0_rd;
    logic [31:0] p0_wd;
    logic        p1_valid;
    logic        p1_ready;
    logic [4:0]  p1_rd;
    logic [31:0] p1_wd;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        iss_conflict;
    logic        reg_write;
    logic [4:0]  rd;
    logic [31:0] wd;

    int n_checks = 0;
    int n_pass   = 0;

    wb_arbiter #(
        .XLEN (32),
        .NREG (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .p0_valid     (p0_valid),
        .p0_ready     (p0_ready),
        .p0_rd        (p0_rd),
        .p0_wd        (p0_wd),
        .p1_valid     (p1_valid),
        .p1_ready     (p1_ready),
        .p1_rd        (p1_rd),
        .p1_wd        (p1_wd),
        .iss_valid    (iss_valid),
        .iss_rd       (iss_rd),
        .rs1          (rs1),
        .rs2          (rs2),
        .rs1_busy     (rs1_busy),
        .rs2_busy     (rs2_busy),
        .iss_conflict (iss_conflict),
        .reg_write    (reg_write),
        .rd           (rd),
        .wd           (wd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        p0_valid  = 1'b0;
        p0_rd     = '0;
        p0_wd     = '0;
        p1_valid  = 1'b0;
        p1_rd     = '0;
        p1_wd     = '0;
        iss_valid = 1'b0;
        iss_rd    = '0;
    endtask

    task automatic pulse_reset();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    // Tie sequence: expected winner per cycle (1 = p0) and destination.
    logic [3:0] tie_p0 = 4'b0101;   // bit k: cycle k, p0 wins on k = 0, 2
    logic [4:0] tie_rd [4] = '{5'd1, 5'd2, 5'd1, 5'd2};

    initial begin
        idle_inputs();
        rs1   = '0;
        rs2   = '0;
        rst_n = 1'b0;

        // Reset state, with both requesters and an issue asserted.
        p0_valid  = 1'b1;
        p1_valid  = 1'b1;
        iss_valid = 1'b1;
        iss_rd    = 5'd3;
        rs1       = 5'd3;
        #2;
        chk("rst_p0_ready", 64'(p0_ready), 64'd0);
        chk("rst_p1_ready", 64'(p1_ready), 64'd0);
        chk("rst_reg_write", 64'(reg_write), 64'd0);
        chk("rst_rd", 64'(rd), 64'd0);
        chk("rst_wd", 64'(wd), 64'd0);
        chk("rst_conflict", 64'(iss_conflict), 64'd0);
        chk("rst_rs1_busy", 64'(rs1_busy), 64'd0);
        cyc();
        chk("rst_hold_busy", 64'(rs1_busy), 64'd0);
        idle_inputs();
        rs1   = '0;
        rst_n = 1'b1;

        // Single p0 write, first edge after release.
        p0_valid = 1'b1;
        p0_rd    = 5'd5;
        p0_wd    = 32'hDEAD_BEEF;
        #1;
        chk("p0_only_ready", 64'(p0_ready), 64'd1);
        chk("p0_only_p1_ready", 64'(p1_ready), 64'd0);
        chk("pre_write_idle", 64'(reg_write), 64'd0);
        cyc();
        p0_valid = 1'b0;
        chk("p0_reg_write", 64'(reg_write), 64'd1);
        chk("p0_rd", 64'(rd), 64'd5);
        chk("p0_wd", 64'(wd), 64'hDEAD_BEEF);
        cyc();
        chk("p0_no_repeat", 64'(reg_write), 64'd0);

        // Round-robin tie from a fresh reset: p0, p1, p0, p1.
        pulse_reset();
        p0_valid = 1'b1;
        p0_rd    = 5'd1;
        p0_wd    = 32'h0000_00A1;
        p1_valid = 1'b1;
        p1_rd    = 5'd2;
        p1_wd    = 32'h0000_00B2;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("tie%0d_p0_ready", k), 64'(p0_ready), 64'(tie_p0[k]));
            chk($sformatf("tie%0d_p1_ready", k), 64'(p1_ready), 64'(!tie_p0[k]));
            if (k > 0) begin
                chk($sformatf("tie%0d_prev_rd", k), 64'(rd), 64'(tie_rd[k-1]));
                chk($sformatf("tie%0d_prev_we", k), 64'(reg_write), 64'd1);
            end
            cyc();
            #1;
        end
        idle_inputs();
        #1;
        chk("tie_last_rd", 64'(rd), 64'd2);
        chk("tie_last_wd", 64'(wd), 64'h0000_00B2);

        // Issue to x7, lookup, then p1 writeback clears it.
        pulse_reset();
        iss_valid = 1'b1;
        iss_rd    = 5'd7;
        cyc();
        iss_valid = 1'b0;
        rs1       = 5'd7;
        rs2       = 5'd8;
        #1;
        chk("sb7_rs1_busy", 64'(rs1_busy), 64'd1);
        chk("sb8_rs2_busy", 64'(rs2_busy), 64'd0);
        chk("sb7_no_conflict", 64'(iss_conflict), 64'd0);
        p1_valid = 1'b1;
        p1_rd    = 5'd7;
        p1_wd    = 32'h0000_0077;
        #1;
        chk("sb7_p1_ready", 64'(p1_ready), 64'd1);
        chk("sb7_busy_during", 64'(rs1_busy), 64'd1);
        cyc();
        p1_valid = 1'b0;
        #1;
        chk("sb7_cleared", 64'(rs1_busy), 64'd0);
        chk("sb7_reg_write", 64'(reg_write), 64'd1);
        chk("sb7_rd", 64'(rd), 64'd7);

        // Same-cycle set and clear of x9 while busy: set wins, conflict pulses.
        iss_valid = 1'b1;
        iss_rd    = 5'd9;
        cyc();
        iss_valid = 1'b0;
        chk("sb9_first_no_conflict", 64'(iss_conflict), 64'd0);
        iss_valid = 1'b1;
        iss_rd    = 5'd9;
        p1_valid  = 1'b1;
        p1_rd     = 5'd9;
        p1_wd     = 32'h0000_0099;
        #1;
        chk("sb9_p1_ready", 64'(p1_ready), 64'd1);
        cyc();
        idle_inputs();
        rs1 = 5'd9;
        #1;
        chk("sb9_conflict", 64'(iss_conflict), 64'd1);
        chk("sb9_still_busy", 64'(rs1_busy), 64'd1);
        cyc();
        chk("sb9_conflict_pulse", 64'(iss_conflict), 64'd0);
        chk("sb9_busy_held", 64'(rs1_busy), 64'd1);

        // x0 handling.
        p1_valid = 1'b1;
        p1_rd    = 5'd0;
        p1_wd    = 32'h0000_0005;
        #1;
        chk("x0_p1_ready", 64'(p1_ready), 64'd1);
        cyc();
        p1_valid  = 1'b0;
        chk("x0_no_write", 64'(reg_write), 64'd0);
        iss_valid = 1'b1;
        iss_rd    = 5'd0;
        cyc();
        iss_valid = 1'b0;
        rs1       = 5'd0;
        #1;
        chk("x0_not_busy", 64'(rs1_busy), 64'd0);
        chk("x0_no_conflict", 64'(iss_conflict), 64'd0);

        // Reset the cycle after an acceptance.
        iss_valid = 1'b1;
        iss_rd    = 5'd3;
        p0_valid  = 1'b1;
        p0_rd     = 5'd4;
        p0_wd     = 32'h0000_0044;
        cyc();
        idle_inputs();
        rs1 = 5'd3;
        rs2 = 5'd9;
        #1;
        chk("mid_we_before", 64'(reg_write), 64'd1);
        chk("mid_busy_before", 64'(rs1_busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_we_now", 64'(reg_write), 64'd0);
        chk("mid_rd_now", 64'(rd), 64'd0);
        chk("mid_busy3_now", 64'(rs1_busy), 64'd0);
        chk("mid_busy9_now", 64'(rs2_busy), 64'd0);
        rst_n = 1'b1;
        cyc();
        chk("mid_no_write1", 64'(reg_write), 64'd0);
        cyc();
        chk("mid_no_write2", 64'(reg_write), 64'd0);
        chk("mid_busy_after", 64'(rs1_busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
